// File: rtl/python_timing_gen.sv
// python_timing_gen: frame/line timing generator and multi-channel test-pattern source.
// Produces o_fval/o_lval framing and a ramp pattern from run-time geometry that is
// latched once per frame, so geometry changes never tear a frame in progress.
//
// Ports:
//   clk            pixel clock, rising-edge logic
//   reset_n        asynchronous active-low reset
//   i_enable       level; high = generate frames back-to-back
//   iv_setup       S: fval-high/lval-low cycles before the first and after the last line
//   iv_line_pix    P: lval-high cycles per line
//   iv_line_hide   H: lval-low cycles between lines
//   iv_frame_line  L: active lines per frame
//   iv_frame_hide  V: fval-low cycles after each frame
//   o_fval         frame valid
//   o_lval         line valid (only while o_fval)
//   ov_pix_data    CHANNEL_NUM pixels of DATA_WIDTH bits, channel k in slice k
//   o_frame_done   one-cycle pulse on the first vertical-blank cycle
module python_timing_gen #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_enable,
    input  logic [CNT_WIDTH-1:0]              iv_setup,
    input  logic [CNT_WIDTH-1:0]              iv_line_pix,
    input  logic [CNT_WIDTH-1:0]              iv_line_hide,
    input  logic [CNT_WIDTH-1:0]              iv_frame_line,
    input  logic [CNT_WIDTH-1:0]              iv_frame_hide,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic                              o_frame_done
);

    localparam int unsigned PIX_W = DATA_WIDTH * CHANNEL_NUM;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] PIX_STEP = DATA_WIDTH'(CHANNEL_NUM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LINE,
        ST_HIDE,
        ST_TAIL,
        ST_VBLANK
    } state_t;

    // A zero-length field would make a state vanish; clamp to one cycle instead.
    function automatic logic [CNT_WIDTH-1:0] min_one(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    // Pack one clock of pixels: channel k carries base + k.
    function automatic logic [PIX_W-1:0] pix_word(input logic [DATA_WIDTH-1:0] base);
        logic [PIX_W-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
            w[k*DATA_WIDTH +: DATA_WIDTH] = base + DATA_WIDTH'(k);
        end
        return w;
    endfunction

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    r_line;
    logic [DATA_WIDTH-1:0]   r_pix_base;

    logic [CNT_WIDTH-1:0]    r_setup;
    logic [CNT_WIDTH-1:0]    r_pix;
    logic [CNT_WIDTH-1:0]    r_hide;
    logic [CNT_WIDTH-1:0]    r_lines;
    logic [CNT_WIDTH-1:0]    r_vhide;

    logic                    r_fval;
    logic                    r_lval;
    logic [PIX_W-1:0]        r_pix_data;
    logic                    r_frame_done;

    logic [CNT_WIDTH-1:0]    w_dur;
    logic                    w_last;
    logic                    w_last_line;
    logic                    w_latch;

    // Length of the current state from the latched geometry.
    always_comb begin
        w_dur = CNT_ONE;
        case (r_state)
            ST_SETUP,
            ST_TAIL:   w_dur = r_setup;
            ST_LINE:   w_dur = r_pix;
            ST_HIDE:   w_dur = r_hide;
            ST_VBLANK: w_dur = r_vhide;
            default:   w_dur = CNT_ONE;
        endcase
    end

    assign w_last      = (r_cnt == (w_dur - CNT_ONE));
    assign w_last_line = (r_line == (r_lines - CNT_ONE));
    // Geometry is captured on exactly the edge that enters SETUP.
    assign w_latch     = i_enable &&
                         ((r_state == ST_IDLE) || ((r_state == ST_VBLANK) && w_last));

    // Per-frame geometry snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_setup <= CNT_ONE;
            r_pix   <= CNT_ONE;
            r_hide  <= CNT_ONE;
            r_lines <= CNT_ONE;
            r_vhide <= CNT_ONE;
        end else if (w_latch) begin
            r_setup <= min_one(iv_setup);
            r_pix   <= min_one(iv_line_pix);
            r_hide  <= min_one(iv_line_hide);
            r_lines <= min_one(iv_frame_line);
            r_vhide <= min_one(iv_frame_hide);
        end
    end

    // Timing FSM; outputs are loaded with the values of the state being entered,
    // so they change on the same edge as the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_pix_base   <= '0;
            r_fval       <= 1'b0;
            r_lval       <= 1'b0;
            r_pix_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= '0;
                        r_line  <= '0;
                        r_fval  <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (w_last) begin
                        r_state    <= ST_LINE;
                        r_cnt      <= '0;
                        r_lval     <= 1'b1;
                        r_pix_base <= '0;
                        r_pix_data <= pix_word('0);
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_LINE: begin
                    if (w_last) begin
                        r_state    <= w_last_line ? ST_TAIL : ST_HIDE;
                        r_cnt      <= '0;
                        r_lval     <= 1'b0;
                        r_pix_data <= '0;
                    end else begin
                        r_cnt      <= r_cnt + CNT_ONE;
                        r_pix_base <= r_pix_base + PIX_STEP;
                        r_pix_data <= pix_word(r_pix_base + PIX_STEP);
                    end
                end

                ST_HIDE: begin
                    if (w_last) begin
                        // Each line's ramp starts at its line index.
                        r_state    <= ST_LINE;
                        r_cnt      <= '0;
                        r_line     <= r_line + CNT_ONE;
                        r_lval     <= 1'b1;
                        r_pix_base <= DATA_WIDTH'(r_line + CNT_ONE);
                        r_pix_data <= pix_word(DATA_WIDTH'(r_line + CNT_ONE));
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_TAIL: begin
                    if (w_last) begin
                        r_state      <= ST_VBLANK;
                        r_cnt        <= '0;
                        r_fval       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_VBLANK: begin
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_line <= '0;
                        if (i_enable) begin
                            r_state <= ST_SETUP;
                            r_fval  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= '0;
                    r_fval     <= 1'b0;
                    r_lval     <= 1'b0;
                    r_pix_data <= '0;
                end
            endcase
        end
    end

    assign o_fval       = r_fval;
    assign o_lval       = r_lval;
    assign ov_pix_data  = r_pix_data;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_python_timing_gen.sv
// tb_python_timing_gen: directed bench for python_timing_gen. Expected per-cycle
// outputs are built from the frame geometry into a queue and compared each cycle.
module tb_python_timing_gen;

    localparam int unsigned DW = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic          fval;
        logic          lval;
        logic [DW*CH-1:0] data;
        logic          done;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_enable = 1'b0;
    logic [CW-1:0]    iv_setup = '0;
    logic [CW-1:0]    iv_line_pix = '0;
    logic [CW-1:0]    iv_line_hide = '0;
    logic [CW-1:0]    iv_frame_line = '0;
    logic [CW-1:0]    iv_frame_hide = '0;
    logic             o_fval;
    logic             o_lval;
    logic [DW*CH-1:0] ov_pix_data;
    logic             o_frame_done;

    exp_t  q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string cur_tag = "init";

    python_timing_gen #(
        .DATA_WIDTH  (DW),
        .CHANNEL_NUM (CH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_enable      (i_enable),
        .iv_setup      (iv_setup),
        .iv_line_pix   (iv_line_pix),
        .iv_line_hide  (iv_line_hide),
        .iv_frame_line (iv_frame_line),
        .iv_frame_hide (iv_frame_hide),
        .o_fval        (o_fval),
        .o_lval        (o_lval),
        .ov_pix_data   (ov_pix_data),
        .o_frame_done  (o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        exp_t obs;
        obs = '{fval: o_fval, lval: o_lval, data: ov_pix_data, done: o_frame_done};
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: fval/lval/data/done observed %b/%b/%h/%b expected %b/%b/%h/%b",
                   cur_tag, obs.fval, obs.lval, obs.data, obs.done,
                   e.fval, e.lval, e.data, e.done);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back('0);
    endtask

    // Expected frame built segment by segment from the geometry.
    task automatic push_frame(input int unsigned s0, input int unsigned p0,
                              input int unsigned h0, input int unsigned l0,
                              input int unsigned v0);
        int unsigned s, p, h, l, v;
        exp_t e;
        logic [DW-1:0] val;
        s = (s0 == 0) ? 1 : s0;
        p = (p0 == 0) ? 1 : p0;
        h = (h0 == 0) ? 1 : h0;
        l = (l0 == 0) ? 1 : l0;
        v = (v0 == 0) ? 1 : v0;
        for (int unsigned i = 0; i < s; i++) q.push_back('{fval: 1'b1, lval: 1'b0, data: '0, done: 1'b0});
        for (int unsigned li = 0; li < l; li++) begin
            for (int unsigned n = 0; n < p; n++) begin
                e = '{fval: 1'b1, lval: 1'b1, data: '0, done: 1'b0};
                for (int unsigned k = 0; k < CH; k++) begin
                    val = DW'(n * CH + k + li);
                    e.data[k*DW +: DW] = val;
                end
                q.push_back(e);
            end
            if (li + 1 < l)
                for (int unsigned i = 0; i < h; i++) q.push_back('{fval: 1'b1, lval: 1'b0, data: '0, done: 1'b0});
        end
        for (int unsigned i = 0; i < s; i++) q.push_back('{fval: 1'b1, lval: 1'b0, data: '0, done: 1'b0});
        for (int unsigned i = 0; i < v; i++) q.push_back('{fval: 1'b0, lval: 1'b0, data: '0, done: (i == 0)});
    endtask

    task automatic run_n(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL %s: scoreboard empty, observed fval %b expected an entry", cur_tag, o_fval);
            end else begin
                e = q.pop_front();
                check(e);
            end
        end
    endtask

    task automatic run_all();
        while (q.size() != 0) run_n(1);
    endtask

    task automatic set_geom(input int unsigned s, input int unsigned p, input int unsigned h,
                            input int unsigned l, input int unsigned v);
        iv_setup      = CW'(s);
        iv_line_pix   = CW'(p);
        iv_line_hide  = CW'(h);
        iv_frame_line = CW'(l);
        iv_frame_hide = CW'(v);
    endtask

    initial begin
        // Reset held with enable high: everything quiet.
        cur_tag = "reset";
        set_geom(2, 4, 3, 2, 5);
        i_enable = 1'b1;
        push_idle(3);
        run_all();

        // Release: frame 1 basic geometry; P changed to 6 during frame 1,
        // enable dropped in line 0 of frame 2, which must still complete.
        cur_tag = "basic_frame";
        reset_n = 1'b1;
        push_frame(2, 4, 3, 2, 5);
        run_n(3);
        iv_line_pix = CW'(6);
        push_frame(2, 6, 3, 2, 5);
        run_n(17);
        cur_tag = "geom_change_frame2";
        run_n(4);
        i_enable = 1'b0;
        push_idle(6);
        run_all();

        // All-zero geometry behaves as all ones.
        cur_tag = "zero_geom";
        set_geom(0, 0, 0, 0, 0);
        i_enable = 1'b1;
        push_frame(0, 0, 0, 0, 0);
        run_n(1);
        i_enable = 1'b0;
        push_idle(3);
        run_all();

        // Reset pulse during LINE clears outputs without waiting for a clock.
        cur_tag = "mid_reset";
        set_geom(2, 4, 3, 2, 5);
        i_enable = 1'b1;
        push_frame(2, 4, 3, 2, 5);
        run_n(4);
        q.delete();
        reset_n = 1'b0;
        #1;
        check('0);
        push_idle(2);
        run_all();

        cur_tag = "restart";
        reset_n = 1'b1;
        push_frame(2, 4, 3, 2, 5);
        run_n(1);
        i_enable = 1'b0;
        push_idle(3);
        run_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
